// File: rtl/uart_reg_cmd.sv
// uart_reg_cmd
//   Command parser between the UART rx/tx pair and the register file.
//   Assembles 'R' addr / 'W' addr data frames. It runs the register-file
//   strobe handshake and returns read data, ACK (06) or NAK (15). A partial
//   frame is dropped after TIMEOUT idle clocks between bytes.
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   rx_data/rx_valid          received byte, one-cycle pulse per byte
//   rf_data/rf_read/rf_write  register file data_in and level strobes
//   rf_rdata/rf_valid         register file data_out and valid
//   tx_data/tx_valid/tx_ready byte to transmit, valid/ready handshake
//   busy                      not IDLE
//   overrun                   sticky: byte arrived while it could not be taken
module uart_reg_cmd #(
  parameter int unsigned TIMEOUT  = 43400,
  parameter int unsigned MAX_ADDR = 14,
  parameter logic [7:0]  CMD_RD   = 8'h52,
  parameter logic [7:0]  CMD_WR   = 8'h57
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] rf_data,
  output logic       rf_read,
  output logic       rf_write,
  input  logic [7:0] rf_rdata,
  input  logic       rf_valid,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       busy,
  output logic       overrun
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TMO_MAX = CW'(TIMEOUT);
  localparam logic [7:0]    MAX_A   = 8'(MAX_ADDR);
  localparam logic [7:0]    ACK     = 8'h06;
  localparam logic [7:0]    NAK     = 8'h15;

  localparam logic [2:0] IDLE       = 3'd0;
  localparam logic [2:0] GET_ADDR   = 3'd1;
  localparam logic [2:0] GET_DATA   = 3'd2;
  localparam logic [2:0] RF_ADDR    = 3'd3;
  localparam logic [2:0] RF_HOLD    = 3'd4;
  localparam logic [2:0] RF_RELEASE = 3'd5;
  localparam logic [2:0] TX         = 3'd6;

  typedef struct packed {
    logic       wr;
    logic [7:0] addr;
    logic [7:0] data;
  } frame_t;

  logic [2:0]    state, state_nxt;
  logic [CW-1:0] tmo_cnt;
  frame_t        frm;
  logic          in_get, tmo_fire, is_cmd, rx_bad, frm_bad;

  assign in_get   = (state == GET_ADDR) || (state == GET_DATA);
  // Timeout has priority over a byte arriving on the same cycle.
  assign tmo_fire = in_get && (tmo_cnt == TMO_MAX);
  assign is_cmd   = (rx_data == CMD_RD) || (rx_data == CMD_WR);
  assign rx_bad   = rx_data > MAX_A;
  assign frm_bad  = frm.addr > MAX_A;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:       if (rx_valid && is_cmd) state_nxt = GET_ADDR;
      GET_ADDR:
        if (tmo_fire)      state_nxt = IDLE;
        else if (rx_valid) state_nxt = frm.wr ? GET_DATA : (rx_bad ? TX : RF_ADDR);
      GET_DATA:
        if (tmo_fire)      state_nxt = IDLE;
        else if (rx_valid) state_nxt = frm_bad ? TX : RF_ADDR;
      RF_ADDR:    state_nxt = RF_HOLD;
      RF_HOLD:    if (rf_valid)  state_nxt = RF_RELEASE;
      RF_RELEASE: if (!rf_valid) state_nxt = TX;
      TX:         if (tx_ready)  state_nxt = IDLE;
      default:    state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      busy     <= 1'b0;
      tmo_cnt  <= '0;
      frm      <= '0;
      rf_data  <= '0;
      rf_read  <= 1'b0;
      rf_write <= 1'b0;
      tx_data  <= '0;
      tx_valid <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      state <= state_nxt;
      // busy follows the next state so it is a registered copy of state != IDLE
      busy  <= (state_nxt != IDLE);

      // saturating inter-byte counter, live only while collecting a frame
      if (in_get && !rx_valid) begin
        if (tmo_cnt != TMO_MAX) tmo_cnt <= tmo_cnt + CW'(1);
      end else begin
        tmo_cnt <= '0;
      end

      if (rx_valid && (state == RF_ADDR || state == RF_HOLD ||
                       state == RF_RELEASE || state == TX))
        overrun <= 1'b1;

      case (state)
        IDLE:
          if (rx_valid) frm.wr <= (rx_data == CMD_WR);
        GET_ADDR:
          if (rx_valid && !tmo_fire) begin
            frm.addr <= rx_data;
            if (!frm.wr) begin
              if (rx_bad) begin
                tx_data  <= NAK;
                tx_valid <= 1'b1;
              end else begin
                rf_data <= rx_data;
                rf_read <= 1'b1;
              end
            end
          end
        GET_DATA:
          if (rx_valid && !tmo_fire) begin
            frm.data <= rx_data;
            if (frm_bad) begin
              tx_data  <= NAK;
              tx_valid <= 1'b1;
            end else begin
              rf_data  <= frm.addr;
              rf_write <= 1'b1;
            end
          end
        RF_ADDR:
          rf_data <= frm.data;
        RF_HOLD:
          if (rf_valid) begin
            rf_read  <= 1'b0;
            rf_write <= 1'b0;
            tx_data  <= frm.wr ? ACK : rf_rdata;
          end
        RF_RELEASE:
          if (!rf_valid) tx_valid <= 1'b1;
        TX:
          if (tx_ready) tx_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_reg_cmd.sv
module tb_uart_reg_cmd;
  localparam int TIMEOUT = 43400;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] rf_data;
  logic       rf_read, rf_write;
  logic [7:0] rf_rdata;
  logic       rf_valid;
  logic [7:0] tx_data;
  logic       tx_valid, tx_ready;
  logic       busy, overrun;

  always #5 clk = ~clk;

  uart_reg_cmd #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .rf_data(rf_data), .rf_read(rf_read), .rf_write(rf_write),
    .rf_rdata(rf_rdata), .rf_valid(rf_valid), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .busy(busy), .overrun(overrun)
  );

  // Register file model: valid rises rf_lat cycles after the strobe rises,
  // falls the cycle after the strobe drops. Contents reset to 40+i.
  logic [7:0] mem [16];
  int         rf_lat = 2;
  int         rf_cnt;
  logic [7:0] rf_addr_l;

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) mem[i] <= 8'h40 + 8'(i);
      rf_cnt   <= 0;
      rf_valid <= 1'b0;
      rf_rdata <= 8'h00;
    end else if (rf_read || rf_write) begin
      if (rf_cnt == 0) rf_addr_l <= rf_data;
      rf_cnt <= rf_cnt + 1;
      if (rf_cnt + 1 == rf_lat) begin
        rf_valid <= 1'b1;
        if (rf_write) mem[rf_addr_l[3:0]] <= rf_data;
        else          rf_rdata <= mem[rf_addr_l[3:0]];
      end
    end else begin
      rf_cnt   <= 0;
      rf_valid <= 1'b0;
    end
  end

  int vectors = 0, miscompares = 0;
  int rd_rise = 0, wr_rise = 0, viol = 0;
  logic prev_rd = 1'b0, prev_wr = 1'b0;
  logic [7:0] exp_q [$];

  task automatic chk(input string nm, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every transmit handshake.
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      if (rf_read && rf_write) viol++;
      if (rf_read && !prev_rd) rd_rise++;
      if (rf_write && !prev_wr) wr_rise++;
      if (tx_valid && tx_ready) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL tx_unexpected: got %02h expected no byte", tx_data);
        end else begin
          chk("tx_byte", int'(tx_data), int'(exp_q.pop_front()));
        end
      end
    end
    prev_rd = rf_read;
    prev_wr = rf_write;
  end

  task automatic send(input logic [7:0] b);
    @(posedge clk); #1;
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while (busy && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    chk({nm, "_idle"}, int'(busy), 0);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, r0, w0, bad;
    rst = 1'b1; rx_data = 8'h00; rx_valid = 1'b0; tx_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset_outs", int'({rf_data, rf_read, rf_write, tx_data, tx_valid, busy, overrun}), 0);

    // write 57 03 A5
    exp_q.push_back(8'h06);
    send(8'h57); send(8'h03); send(8'hA5);
    chk("wr_strobe", int'({rf_write, rf_read}), 2);
    chk("wr_addr", int'(rf_data), 8'h03);
    @(posedge clk); #1;
    chk("wr_data", int'(rf_data), 8'hA5);
    chk("wr_hold", int'(rf_write), 1);
    wait_idle("wr");
    chk("wr_rises", wr_rise, 1);

    // read back 52 03
    exp_q.push_back(8'hA5);
    send(8'h52); send(8'h03);
    chk("rd_strobe", int'({rf_write, rf_read}), 1);
    chk("rd_addr", int'(rf_data), 8'h03);
    n = 0;
    while (!tx_valid && n < 20) begin @(posedge clk); #1; n++; end
    chk("rd_latency_le6", int'(n <= 5), 1);
    wait_idle("rd");

    // illegal addresses
    r0 = rd_rise; w0 = wr_rise;
    exp_q.push_back(8'h15);
    send(8'h57); send(8'h0F); send(8'h11);
    chk("nak_wr_valid", int'(tx_valid), 1);
    chk("nak_wr_data", int'(tx_data), 8'h15);
    wait_idle("nak_wr");
    exp_q.push_back(8'h15);
    send(8'h52); send(8'h20);
    chk("nak_rd_valid", int'(tx_valid), 1);
    wait_idle("nak_rd");
    chk("nak_no_strobe", rd_rise + wr_rise, r0 + w0);

    // junk byte in IDLE
    send(8'h33);
    chk("junk_busy", int'(busy), 0);

    // 52 then silence; a byte lands exactly on the timeout edge
    r0 = rd_rise;
    send(8'h52);
    repeat (TIMEOUT - 1) @(posedge clk);
    #1 chk("tmo_still_busy", int'(busy), 1);
    send(8'h05);
    chk("tmo_idle", int'(busy), 0);
    chk("tmo_no_overrun", int'(overrun), 0);
    repeat (5) @(posedge clk);
    #1 chk("tmo_no_read", rd_rise, r0);

    exp_q.push_back(8'h45);
    send(8'h52); send(8'h05);
    wait_idle("after_tmo");

    // overrun during RF_HOLD
    rf_lat = 12;
    exp_q.push_back(8'hA5);
    send(8'h52); send(8'h03);
    send(8'h99);
    chk("ovr_set", int'(overrun), 1);
    wait_idle("ovr");
    chk("ovr_sticky", int'(overrun), 1);
    rf_lat = 2;

    // backpressure
    tx_ready = 1'b0;
    exp_q.push_back(8'h41);
    send(8'h52); send(8'h01);
    n = 0;
    while (!tx_valid && n < 20) begin @(posedge clk); #1; n++; end
    chk("bp_valid", int'(tx_valid), 1);
    bad = 0;
    repeat (50) begin
      @(posedge clk); #1;
      if (!tx_valid || tx_data != 8'h41) bad++;
    end
    chk("bp_stable", bad, 0);
    tx_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_done", int'({busy, tx_valid}), 0);

    // reset during RF_HOLD, response lost
    rf_lat = 12;
    send(8'h52); send(8'h02);
    @(posedge clk); #1;
    chk("rst_in_hold", int'(rf_read), 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    rf_lat = 2;
    chk("rst_outs_mid", int'({rf_data, rf_read, rf_write, tx_data, tx_valid, busy, overrun}), 0);
    exp_q.push_back(8'h06);
    send(8'h57); send(8'h01); send(8'h7E);
    chk("post_rst_wr", int'(rf_write), 1);
    wait_idle("post_rst_wr");
    exp_q.push_back(8'h7E);
    send(8'h52); send(8'h01);
    wait_idle("post_rst_rd");

    repeat (5) @(posedge clk);
    #1;
    chk("queue_empty", exp_q.size(), 0);
    chk("strobe_onehot", viol, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/uart_reg_cmd.md
# uart_reg_cmd

Command parser between the UART receiver/transmitter pair and the register file. It assembles received bytes into read/write frames and drives the register file's address/read/write strobe handshake. It returns read data or an ACK/NAK byte to the UART transmitter, and discards partial frames after an inter-byte timeout.

## Interface
- `TIMEOUT`, 43400: clocks allowed between bytes of one frame (about 10 byte times at 434 clk/bit).
- `MAX_ADDR`, 14: highest legal register address.
- `CMD_RD`, 8'h52: read command byte ('R').
- `CMD_WR`, 8'h57: write command byte ('W').
- `clk` in 1: system clock. One clock domain.
- `rst` in 1: reset, synchronous, active-high.
- `rx_data` in 8: received byte, valid only while `rx_valid`=1.
- `rx_valid` in 1: one-cycle pulse per received byte.
- `rf_data` out 8: to register file `data_in`. Carries the address, then the write data.
- `rf_read` out 1: register file read strobe, held as a level.
- `rf_write` out 1: register file write strobe, held as a level.
- `rf_rdata` in 8: register file `data_out`.
- `rf_valid` in 1: register file `valid`.
- `tx_data` out 8: byte to transmit.
- `tx_valid` out 1: transmit request. A transfer occurs on a cycle where `tx_valid` and `tx_ready` are both 1.
- `tx_ready` in 1: transmitter idle.
- `busy` out 1: high whenever state is not IDLE.
- `overrun` out 1: sticky. Set when a byte arrives in a state that cannot accept it. Cleared only by `rst`.

## Operation
- Frames:
  - Read: `CMD_RD`, addr.
  - Write: `CMD_WR`, addr, data.
- Responses:
  - Read: one byte, the register value.
  - Write: 8'h06 (ACK).
  - Illegal address (addr > `MAX_ADDR`): 8'h15 (NAK). The register file is not accessed. For a write, the data byte is still consumed before the NAK is sent.
  - Unknown command byte in IDLE: silently ignored, stays in IDLE, no response.
- States and transitions:
  - IDLE: on `rx_valid`, a legal command byte latches the op and goes to GET_ADDR.
  - GET_ADDR: on `rx_valid`, latch the address.
    - Write: go to GET_DATA.
    - Read with legal address: go to RF_ADDR.
    - Read with illegal address: go to TX.
  - GET_DATA: on `rx_valid`, latch data. Legal address goes to RF_ADDR; illegal address goes to TX with NAK.
  - RF_ADDR (1 cycle): `rf_data`=addr, `rf_read` or `rf_write`=1. Go to RF_HOLD.
  - RF_HOLD: `rf_data`=write data (don't-care for reads), strobe held. When `rf_valid`=1: latch `rf_rdata` as the response (read) or load ACK (write), drop the strobe, go to RF_RELEASE.
  - RF_RELEASE: strobes 0. Wait for `rf_valid`=0, then go to TX.
  - TX: `tx_valid`=1 with `tx_data` stable. On `tx_ready`=1, the transfer completes; go to IDLE.
- Only one strobe is ever high. `rf_read` and `rf_write` are never both 1.
- Timeout counter:
  - Cleared on every accepted byte; counts only in GET_ADDR and GET_DATA.
  - Reaching `TIMEOUT` returns the block to IDLE with no response and no register access.
- `rx_valid` in RF_ADDR, RF_HOLD, RF_RELEASE or TX: the byte is dropped and `overrun` is set. State is unaffected.

## Timing
- Reset values: `rf_data`=0, `rf_read`=0, `rf_write`=0, `tx_data`=0, `tx_valid`=0, `busy`=0, `overrun`=0, state IDLE, timeout counter 0.
- All outputs are registered.
- Strobe timing: the strobe rises the cycle after the final frame byte is accepted. `rf_data` changes from address to data exactly one cycle later, when RF_HOLD is entered.
- Latency with a register file that reports `rf_valid` 2 cycles after the strobe rises:
  - Final rx byte to `tx_valid`=1 is at most 6 cycles.
  - Illegal-address NAK reaches `tx_valid` 1 cycle after the final byte.
- `rst` asserted mid-operation: all strobes and `tx_valid` drop on the next edge, and any pending response is lost.
- `rx_valid` in the same cycle the timeout fires: the timeout wins and the byte is dropped.
  - The block is in IDLE afterwards.
  - `overrun` is not set.
- Counter width is `$clog2(TIMEOUT+1)`. It saturates and does not wrap.

## Test plan
- Write then read back: frames 57 03 A5, then 52 03.
  - One `rf_write` cycle pair with `rf_data` 03 then A5; tx sends 06.
  - Then `rf_read`; tx sends A5.
- Illegal address: frames 57 0F 11, then 52 20.
  - `rf_read` and `rf_write` never rise.
  - tx sends 15 twice.
- Junk and timeout:
  - Byte 33 in IDLE: ignored, `busy` stays 0.
  - 52 followed by silence for `TIMEOUT` cycles: returns to IDLE with no tx.
  - A following 52 05 works normally.
- Overrun: byte sent while in RF_HOLD (hold `rf_valid` low 10 cycles).
  - `overrun`=1 and stays set.
  - The original transaction still completes with the correct response.
- Backpressure: `tx_ready`=0 for 50 cycles after a read.
  - `tx_valid` and `tx_data` stay stable.
  - Transfer happens on the first `tx_ready`=1; `busy` falls the next cycle.
- Reset mid-RF_HOLD: `rst` pulses for 1 cycle.
  - All outputs at reset values the next cycle.
  - A subsequent 57 01 7E is accepted normally.
